// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_arbiter                                               |
// | Purpose  : shares one registered ALU between two requesters and returns    |
// |            tagged results in issue order through a response FIFO.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_issue_arbiter #(
  parameter int ARB_MODE   = 0,
  parameter int RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_op,
  input  logic [31:0] a_d1,
  input  logic [31:0] a_d2,
  input  logic [4:0]  a_sh,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_op,
  input  logic [31:0] b_d1,
  input  logic [31:0] b_d2,
  input  logic [4:0]  b_sh,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_d1,
  output logic [31:0] alu_d2,
  output logic [4:0]  alu_sh,
  input  logic [31:0] alu_result,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_ovf,
  output logic        resp_zero,
  output logic        resp_err
);

  localparam int         c_PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int         c_CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [3:0] c_OP_MAX = 4'd9;
  localparam logic [3:0] c_OP_SUB = 4'd1;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic        err;
  } resp_t;

  resp_t                r_mem [RESP_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_inflight;
  logic                 r_if_id;
  logic                 r_if_err;
  logic                 r_if_ovf_en;
  logic                 r_rr_b;

  logic                 w_gnt_b;
  logic                 w_space;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_head_valid;
  logic [c_CNT_W:0]     w_occ;
  logic [3:0]           w_sel_op;
  logic                 w_sel_err;
  resp_t                w_push_data;
  resp_t                w_head;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Grant selection; with no requester valid the grant parks on the rr/default side.
  generate
    if (ARB_MODE == 1) begin : g_fixed_prio
      assign w_gnt_b = ~a_valid;
    end else begin : g_round_robin
      always_comb begin
        w_gnt_b = r_rr_b;
        if (a_valid && b_valid) w_gnt_b = r_rr_b;
        else if (a_valid)       w_gnt_b = 1'b0;
        else if (b_valid)       w_gnt_b = 1'b1;
      end
    end
  endgenerate

  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid & resp_ready;
  // Occupancy counts the in-flight op so a slot is always reserved for its result.
  assign w_occ        = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight) - (c_CNT_W + 1)'(w_pop);
  assign w_space      = rst_n & ~flush & (w_occ < (c_CNT_W + 1)'(RESP_DEPTH));

  assign a_ready  = w_space & ~w_gnt_b;
  assign b_ready  = w_space &  w_gnt_b;
  assign w_accept = w_space & (w_gnt_b ? b_valid : a_valid);

  assign w_sel_op  = w_gnt_b ? b_op : a_op;
  assign w_sel_err = (w_sel_op > c_OP_MAX);

  always_comb begin
    alu_ctrl = '0;
    alu_d1   = '0;
    alu_d2   = '0;
    alu_sh   = '0;
    if (w_accept) begin
      alu_ctrl = w_sel_err ? 4'd0 : w_sel_op;
      alu_d1   = w_gnt_b ? b_d1 : a_d1;
      alu_d2   = w_gnt_b ? b_d2 : a_d2;
      alu_sh   = w_gnt_b ? b_sh : a_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_if_id     <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_ovf_en <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_if_id     <= w_gnt_b;
        r_if_err    <= w_sel_err;
        r_if_ovf_en <= (w_sel_op <= c_OP_SUB);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_b <= 1'b0;
    end else if (w_accept && (ARB_MODE == 0)) begin
      r_rr_b <= ~w_gnt_b;
    end
  end

  // A flush on the capture edge discards the arriving result.
  assign w_push             = r_inflight & ~flush;
  assign w_push_data.id     = r_if_id;
  assign w_push_data.result = r_if_err ? 32'd0 : alu_result;
  assign w_push_data.ovf    = r_if_ovf_en & alu_ovf;
  assign w_push_data.zero   = alu_zero;
  assign w_push_data.err    = r_if_err;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  assign w_head      = w_head_valid ? r_mem[r_rd_ptr] : '0;
  assign resp_valid  = w_head_valid;
  assign resp_id     = w_head.id;
  assign resp_result = w_head.result;
  assign resp_ovf    = w_head.ovf;
  assign resp_zero   = w_head.zero;
  assign resp_err    = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_issue_arbiter                                            |
// | Purpose  : self-checking bench for alu_issue_arbiter with a queue model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_issue_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [3:0]  a_op, b_op;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic [4:0]  a_sh, b_sh;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_d1, alu_d2;
  logic [4:0]  alu_sh;
  logic [31:0] alu_result = '0;
  logic        alu_ovf = 1'b0, alu_zero = 1'b0;
  logic        resp_valid, resp_ready, resp_id, resp_ovf, resp_zero, resp_err;
  logic [31:0] resp_result;

  int n_chk  = 0;
  int n_pass = 0;

  alu_issue_arbiter #(.ARB_MODE(0), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_d1(a_d1), .a_d2(a_d2), .a_sh(a_sh),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_d1(b_d1), .b_d2(b_d2), .b_sh(b_sh),
    .alu_ctrl(alu_ctrl), .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_sh(alu_sh),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ~(x | y);
      4'd6: return {31'd0, ($signed(x) < $signed(y))};
      4'd7: return y << sh;
      4'd8: return y >> sh;
      4'd9: return $unsigned($signed(y) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Raw ALU overflow; non-arithmetic ops report d1[0] so masking is visible.
  function automatic logic ovf_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] s;
    if (op == 4'd0) begin
      s = x + y;
      return (x[31] == y[31]) && (s[31] != x[31]);
    end else if (op == 4'd1) begin
      s = x - y;
      return (x[31] != y[31]) && (s[31] != x[31]);
    end
    return x[0];
  endfunction

  always @(posedge clk) begin
    alu_result <= alu_f(alu_ctrl, alu_d1, alu_d2, alu_sh);
    alu_ovf    <= ovf_f(alu_ctrl, alu_d1, alu_d2);
    alu_zero   <= (alu_f(alu_ctrl, alu_d1, alu_d2, alu_sh) == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: every accepted op sits in one queue (in-flight or buffered) until popped.
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
    int          vis;
  } ent_t;

  ent_t q[$];
  logic m_rr = 1'b0;
  int   cyc  = 0;

  always @(negedge clk) begin
    ent_t        e;
    logic        head_vis, pop, space, g, acc, gv;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [4:0]  sh;
    int          occ;
    if (!rst_n) begin
      chk("rst a_ready", a_ready, 0);
      chk("rst b_ready", b_ready, 0);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst resp_result", resp_result, 0);
      q.delete();
      m_rr = 1'b0;
    end else begin
      head_vis = (q.size() > 0) && (q[0].vis <= cyc);
      pop      = head_vis && resp_ready;
      occ      = q.size() - (pop ? 1 : 0);
      space    = !flush && (occ < DEPTH);
      if (a_valid && b_valid) g = m_rr;
      else if (a_valid)       g = 1'b0;
      else if (b_valid)       g = 1'b1;
      else                    g = m_rr;
      gv  = g ? b_valid : a_valid;
      acc = space && gv;
      op  = g ? b_op : a_op;
      x   = g ? b_d1 : a_d1;
      y   = g ? b_d2 : a_d2;
      sh  = g ? b_sh : a_sh;

      chk("a_ready", a_ready, space && !g);
      chk("b_ready", b_ready, space && g);
      chk("alu_ctrl", alu_ctrl, (acc && op <= 9) ? op : 4'd0);
      chk("alu_d1", alu_d1, acc ? x : 32'd0);
      chk("alu_d2", alu_d2, acc ? y : 32'd0);
      chk("alu_sh", alu_sh, acc ? sh : 5'd0);
      chk("resp_valid", resp_valid, head_vis);
      chk("resp_id", resp_id, head_vis ? q[0].id : 1'b0);
      chk("resp_result", resp_result, head_vis ? q[0].res : 32'd0);
      chk("resp_ovf", resp_ovf, head_vis ? q[0].ovf : 1'b0);
      chk("resp_zero", resp_zero, head_vis ? q[0].zero : 1'b0);
      chk("resp_err", resp_err, head_vis ? q[0].err : 1'b0);

      cyc++;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.id  = g;
          e.vis = cyc + 1;
          if (op > 9) begin
            e.err = 1'b1; e.res = 32'd0; e.ovf = 1'b0; e.zero = ((x + y) == 32'd0);
          end else begin
            e.err = 1'b0; e.res = alu_f(op, x, y, sh);
            e.ovf = (op <= 1) ? ovf_f(op, x, y) : 1'b0;
            e.zero = (e.res == 32'd0);
          end
          q.push_back(e);
          m_rr = ~g;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; flush = 0;
    a_op = 0; a_d1 = 0; a_d2 = 0; a_sh = 0;
    b_op = 0; b_d1 = 0; b_d2 = 0; b_sh = 0;
  endtask

  task automatic req_a(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    a_valid = 1; a_op = op; a_d1 = x; a_d2 = y; a_sh = 5'd0;
  endtask

  task automatic req_b(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    b_valid = 1; b_op = op; b_d1 = x; b_d2 = y; b_sh = 5'd0;
  endtask

  initial begin
    rst_n = 0; resp_ready = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("lit reset resp_valid", resp_valid, 0);
    chk("lit reset a_ready", a_ready, 0);
    chk("lit reset b_ready", b_ready, 0);
    rst_n = 1;
    step();

    // ADD 5,7 from A: response one edge after issue
    req_a(4'd0, 32'd5, 32'd7);
    step();
    idle();
    chk("lit latency not early", resp_valid, 0);
    step();
    chk("lit add valid", resp_valid, 1);
    chk("lit add id", resp_id, 0);
    chk("lit add result", resp_result, 32'd12);
    chk("lit add ovf", resp_ovf, 0);
    chk("lit add zero", resp_zero, 0);
    step();

    // both requesters valid: alternating grants
    req_a(4'd0, 32'd1, 32'd1);
    req_b(4'd0, 32'd2, 32'd2);
    repeat (4) step();
    idle();
    repeat (3) step();

    // SUB overflow, then AND with masked overflow and zero result
    req_a(4'd1, 32'h8000_0000, 32'd1);
    step();
    idle();
    step();
    chk("lit sub result", resp_result, 32'h7FFF_FFFF);
    chk("lit sub ovf", resp_ovf, 1);
    req_a(4'd2, 32'd3, 32'd4);
    step();
    idle();
    step();
    chk("lit and result", resp_result, 32'd0);
    chk("lit and ovf masked", resp_ovf, 0);
    chk("lit and zero", resp_zero, 1);
    step();

    // illegal opcode from B, then a legal op
    req_b(4'd12, 32'd5, 32'd6);
    step();
    req_b(4'd0, 32'd1, 32'd2);
    step();
    idle();
    chk("lit err flag", resp_err, 1);
    chk("lit err result", resp_result, 0);
    chk("lit err id", resp_id, 1);
    step();
    chk("lit post-err result", resp_result, 32'd3);
    chk("lit post-err err", resp_err, 0);
    step();

    // backpressure fills the FIFO, then drains
    resp_ready = 0;
    req_a(4'd0, 32'd10, 32'd20);
    repeat (3) step();
    chk("lit full a_ready", a_ready, 0);
    chk("lit full resp_valid", resp_valid, 1);
    idle();
    resp_ready = 1;
    repeat (3) step();
    chk("lit drained", resp_valid, 0);

    // flush one cycle after issue drops the response
    req_a(4'd0, 32'd9, 32'd9);
    step();
    idle();
    flush = 1;
    step();
    flush = 0;
    step();
    chk("lit flush drop", resp_valid, 0);

    // async reset with a buffered response
    resp_ready = 0;
    req_a(4'd0, 32'd4, 32'd4);
    repeat (2) step();
    idle();
    chk("lit pre-reset valid", resp_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("lit async rst valid", resp_valid, 0);
    chk("lit async rst a_ready", a_ready, 0);
    chk("lit async rst b_ready", b_ready, 0);
    step();
    rst_n = 1;
    resp_ready = 1;
    step();

    // randomized traffic
    repeat (3000) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_op = ($urandom % 8 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
      b_op = ($urandom % 8 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
      a_d1 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
      a_d2 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
      b_d1 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
      b_d2 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
      a_sh = 5'($urandom);
      b_sh = 5'($urandom);
      resp_ready = ($urandom % 4 != 0);
      flush = ($urandom % 40 == 0);
      step();
    end
    idle();
    resp_ready = 1;
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
